// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: checks an hsync/vsync/RGB stream against VGA timing, locks, and regenerates de/x/y plus a per-frame colour summary
// Ports: clk, rst_n (async active-low), pix_en (pixel tick), hsync/vsync (active-low), r/g/b (4b each)
//        -> locked, de, x (10b), y (9b), pix_rgb (12b), frame_done (1-clk pulse), frame_uniform, frame_color (12b), err_count (8b, saturating)
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        locked,
  output logic        de,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic        frame_uniform,
  output logic [11:0] frame_color,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  localparam logic [10:0] HT  = 11'(H_TOTAL);
  localparam logic [10:0] HS  = 11'(H_SYNC);
  localparam logic [10:0] VT  = 11'(V_TOTAL);
  localparam logic [9:0]  VS  = 10'(V_SYNC);
  localparam logic [9:0]  HA0 = 10'(H_ACT_START);
  localparam logic [9:0]  HA1 = 10'(H_ACT_START + H_ACTIVE - 1);
  localparam logic [9:0]  VA0 = 10'(V_ACT_START);
  localparam logic [9:0]  VA1 = 10'(V_ACT_START + V_ACTIVE - 1);
  localparam logic [7:0]  LF  = 8'(LOCK_FRAMES);
  // a missing hsync for two lines is a timeout; the 10-bit counter caps the threshold at its saturation value
  localparam logic [9:0]  TO  = (2 * H_TOTAL > 1023) ? 10'd1023 : 10'(2 * H_TOTAL);

  state_t state, state_n;
  logic hs_q, hs_p, vs_q, vs_lf;
  logic [11:0] rgb_q, cur_color, cur_n;
  logic [9:0] h_cnt, v_cnt, vs_lines, h_cnt_n, v_cnt_n, vs_lines_n, x_n;
  logic [8:0] y_n;
  logic [7:0] good_cnt, good_n, err_n;
  logic err_flag, err_flag_n, first, first_n, uniform, uniform_n;
  logic fall, rise, fs, line_err, width_err, frame_bad, timeout, done_n, de_n;

  assign locked = (state == LOCKED);

  // h_cnt is the position of the pixel being processed, with the hsync-fall pixel at 0,
  // so the old h_cnt at a fall/rise is one less than the line length / sync width
  always_comb begin
    fall       = hs_p & ~hs_q;
    rise       = ~hs_p & hs_q;
    fs         = fall & ~vs_q & vs_lf;
    line_err   = fall & ({1'b0, h_cnt} + 11'd1 != HT);
    width_err  = rise & ({1'b0, h_cnt} + 11'd1 != HS);
    frame_bad  = ({1'b0, v_cnt} + 11'd1 != VT) | (vs_lines != VS) | err_flag | line_err;
    h_cnt_n    = fall ? 10'd0 : h_cnt + {9'd0, h_cnt != 10'h3FF};
    v_cnt_n    = fs ? 10'd0 : v_cnt + {9'd0, fall & (v_cnt != 10'h3FF)};
    vs_lines_n = fs ? 10'd1 : vs_lines + {9'd0, fall & ~vs_q & (vs_lines != 10'h3FF)};
    err_flag_n = ~fs & (err_flag | line_err | width_err);
    timeout    = h_cnt_n >= TO;
    state_n    = state;
    good_n     = good_cnt;
    err_n      = err_count;
    done_n     = 1'b0;
    case (state)
      SEARCH: if (fs) state_n = ACQUIRE;
      ACQUIRE: if (fs) begin
        good_n = frame_bad ? 8'd0 : good_cnt + 8'd1;
        if (!frame_bad && good_cnt + 8'd1 >= LF) begin
          state_n = LOCKED;
          good_n  = 8'd0;
        end
      end
      LOCKED: if (line_err | width_err | (fs & frame_bad)) begin
        state_n = ACQUIRE;
        good_n  = 8'd0;
        err_n   = err_count + {7'd0, err_count != 8'hFF};
      end else done_n = fs;
      default: state_n = SEARCH;
    endcase
    if (timeout) begin
      state_n = SEARCH;
      good_n  = 8'd0;
    end
    de_n      = (state_n == LOCKED) && h_cnt_n >= HA0 && h_cnt_n <= HA1 && v_cnt_n >= VA0 && v_cnt_n <= VA1;
    x_n       = de_n ? h_cnt_n - HA0 : 10'd0;
    y_n       = de_n ? 9'(v_cnt_n - VA0) : 9'd0;
    first_n   = fs | (first & ~de_n);
    cur_n     = (de_n & first) ? rgb_q : cur_color;
    uniform_n = de_n ? (first | (uniform & (rgb_q == cur_color))) : uniform;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SEARCH;
    else if (pix_en) state <= state_n;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hs_q          <= 1'b1;
      hs_p          <= 1'b1;
      vs_q          <= 1'b1;
      vs_lf         <= 1'b1;
      rgb_q         <= '0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      vs_lines      <= '0;
      err_flag      <= 1'b0;
      good_cnt      <= '0;
      err_count     <= '0;
      first         <= 1'b1;
      uniform       <= 1'b0;
      cur_color     <= '0;
      de            <= 1'b0;
      x             <= '0;
      y             <= '0;
      pix_rgb       <= '0;
      frame_done    <= 1'b0;
      frame_uniform <= 1'b0;
      frame_color   <= '0;
    end else begin
      frame_done <= pix_en & done_n;
      if (pix_en) begin
        hs_q      <= hsync;
        hs_p      <= hs_q;
        vs_q      <= vsync;
        vs_lf     <= fall ? vs_q : vs_lf;
        rgb_q     <= {r, g, b};
        h_cnt     <= h_cnt_n;
        v_cnt     <= v_cnt_n;
        vs_lines  <= vs_lines_n;
        err_flag  <= err_flag_n;
        good_cnt  <= good_n;
        err_count <= err_n;
        first     <= first_n;
        uniform   <= uniform_n;
        cur_color <= cur_n;
        de        <= de_n;
        x         <= x_n;
        y         <= y_n;
        pix_rgb   <= rgb_q;
        if (done_n) begin
          frame_color   <= cur_color;
          frame_uniform <= uniform;
        end
      end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed scoreboard bench for vga_sync_monitor on a scaled-down raster
module tb_vga_sync_monitor;
  localparam int HT = 20, HS = 3, HA0 = 5, HA = 12, VT = 10, VS = 2, VA0 = 3, VA = 5;
  logic clk = 0, rst_n = 1, pix_en = 0, hsync = 1, vsync = 1;
  logic [3:0] r = 0, g = 0, b = 0;
  logic locked, de, frame_done, frame_uniform;
  logic [9:0] x;
  logic [8:0] y;
  logic [11:0] pix_rgb, frame_color;
  logic [7:0] err_count;
  int chk_cnt = 0, pass_cnt = 0, div = 1, de_cnt = 0, fd_cnt = 0;
  logic fd_prev = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA0), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .locked(locked), .de(de), .x(x), .y(y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_uniform(frame_uniform), .frame_color(frame_color),
    .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // one pixel: pix_en high for one clk out of div; expected output for this sample is queued
  // and compared one pixel tick later, when the registered outputs reflect it
  task automatic pix(input logic hs, input logic vs, input logic [11:0] c, input logic e_de, input int h, input int v);
    for (int k = 0; k < div; k++) begin
      pix_en = (k == 0);
      hsync  = hs;
      vsync  = vs;
      {r, g, b} = c;
      if (k == 0) sb.push_back({e_de, e_de ? 10'(h - HA0) : 10'd0, e_de ? 9'(v - VA0) : 9'd0, c});
      @(posedge clk);
      #1;
      if (frame_done) begin
        fd_cnt++;
        chk("fd_single", {63'd0, fd_prev}, 64'd0);
      end
      fd_prev = frame_done;
      if (k == 0) begin
        de_cnt += int'(de);
        if (sb.size() >= 2) chk("pixel", {32'd0, de, x, y, pix_rgb}, {32'd0, sb.pop_front()});
      end
      @(negedge clk);
    end
  endtask

  // one raster frame starting at line 0 / tick 0; lk is the expected lock from the frame-start pixel,
  // a short line drops the expectation from the next hsync fall on; stops after max_px pixels
  task automatic frame(input logic lk, input int short_line, input logic [11:0] c0, input logic [11:0] c1,
                       input int split, input int max_px);
    logic lkc, act;
    int n;
    lkc = lk;
    n = 0;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < ((v == short_line) ? HT - 1 : HT); h++) begin
        if (n == max_px) return;
        if (v == short_line + 1 && h == 0) lkc = 0;
        act = h >= HA0 && h < HA0 + HA && v >= VA0 && v < VA0 + VA;
        pix(h >= HS, v >= VS, act ? ((v - VA0 < split) ? c0 : c1) : 12'h000, lkc && act, h, v);
        n++;
      end
  endtask

  initial begin
    #2 rst_n = 0;
    @(negedge clk);
    chk("reset", {9'd0, locked, de, x, y, pix_rgb, frame_done, frame_uniform, frame_color, err_count}, 64'd0);
    rst_n = 1;
    frame(0, 99, 12'hFFF, 12'hFFF, 0, 9999);
    frame(0, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("unlocked_before_fs3", {63'd0, locked}, 64'd0);
    de_cnt = 0;
    frame(1, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("locked_at_fs3", {63'd0, locked}, 64'd1);
    chk("de_count", 64'(de_cnt), 64'(HA * VA));
    fd_cnt = 0;
    frame(1, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("fd_count_white", 64'(fd_cnt), 64'd1);
    chk("summary_white", {51'd0, frame_uniform, frame_color}, {51'd0, 1'b1, 12'hFFF});
    fd_cnt = 0;
    frame(1, 4, 12'hFFF, 12'hFFF, 0, 9999);
    chk("short_line_unlock", {63'd0, locked}, 64'd0);
    chk("short_line_err", {56'd0, err_count}, 64'd1);
    chk("fd_count_short", 64'(fd_cnt), 64'd1);
    frame(0, 99, 12'hFFF, 12'hFFF, 0, 9999);
    frame(0, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("relock_pending", {63'd0, locked}, 64'd0);
    frame(1, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("relocked", {63'd0, locked}, 64'd1);
    chk("no_fd_bad_frames", 64'(fd_cnt), 64'd1);
    frame(1, 99, 12'hF00, 12'h00F, 2, 9999);
    fd_cnt = 0;
    frame(1, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("fd_count_rb", 64'(fd_cnt), 64'd1);
    chk("summary_rb", {51'd0, frame_uniform, frame_color}, {51'd0, 1'b0, 12'hF00});
    for (int i = 0; i < 100; i++) pix(1, 1, 12'h000, 0, 0, 0);
    chk("timeout_unlock", {63'd0, locked}, 64'd0);
    frame(0, 99, 12'hFFF, 12'hFFF, 0, 9999);
    frame(0, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("timeout_relock_pending", {63'd0, locked}, 64'd0);
    frame(1, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("timeout_relocked", {63'd0, locked}, 64'd1);
    frame(1, 99, 12'hFFF, 12'hFFF, 0, 90);
    chk("pre_reset_state", {54'd0, locked, de, err_count}, {54'd0, 1'b1, 1'b1, 8'd1});
    rst_n = 0;
    #1;
    chk("async_reset", {9'd0, locked, de, x, y, pix_rgb, frame_done, frame_uniform, frame_color, err_count}, 64'd0);
    pix_en = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("err_cleared", {56'd0, err_count}, 64'd0);
    sb.delete();
    fd_prev = 0;
    div = 4;
    frame(0, 99, 12'hFFF, 12'hFFF, 0, 9999);
    frame(0, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("div4_unlocked", {63'd0, locked}, 64'd0);
    de_cnt = 0;
    frame(1, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("div4_locked", {63'd0, locked}, 64'd1);
    chk("div4_de_count", 64'(de_cnt), 64'(HA * VA));
    fd_cnt = 0;
    frame(1, 99, 12'hFFF, 12'hFFF, 0, 9999);
    chk("div4_fd_count", 64'(fd_cnt), 64'd1);
    chk("div4_summary", {51'd0, frame_uniform, frame_color}, {51'd0, 1'b1, 12'hFFF});
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
